// File: rtl/i2c_slave_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slave_ctrl
//
// I2C slave protocol engine for a 256x8 register block. It decodes START,
// STOP, the device address, a register pointer and data bytes from the raw
// SCL/SDA lines. Written bytes reach the register block as one-clock write
// strobes. On reads, register contents are serialised back to the master.
// The register pointer auto-increments, so multi-byte bursts work in both
// directions.
//
// Parameters:
//   SLAVE_ADDR  7-bit device address this slave answers to (default 7'h50)
//
// Ports:
//   clk      in   system clock, at least 16x the SCL frequency
//   rst_n    in   asynchronous active-low reset
//   scl_i    in   raw SCL line (asynchronous)
//   sda_i    in   raw SDA line (asynchronous)
//   sda_oe   out  1 = pull SDA low (open drain), 0 = release
//   we       out  register block write enable, one-clock pulse
//   DI       out  register block write data
//   Adr_wr   out  register block write address
//   Adr_rd   out  register block read address (always the pointer)
//   dat_REG  in   register block read data, combinational from Adr_rd
//   busy     out  high from an address match until STOP, or until the next
//                 START after a NACK/mismatch
// ---------------------------------------------------------------------------
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       we,
    output logic [7:0] DI,
    output logic [7:0] Adr_wr,
    output logic [7:0] Adr_rd,
    input  logic [7:0] dat_REG,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    // Line synchronisers and history flops
    logic [1:0] r_sclSync;
    logic [1:0] r_sdaSync;
    logic       r_sclHist;
    logic       r_sdaHist;

    // Protocol state
    state_t     r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bitCnt;
    logic       r_rw;
    logic       r_phase;
    logic [7:0] r_ptr;
    logic       r_incPending;
    logic       r_sdaOe;
    logic       r_we;
    logic [7:0] r_di;
    logic [7:0] r_adrWr;
    logic       r_busy;

    // Next-state values
    state_t     w_stateNxt;
    logic [7:0] w_shregNxt;
    logic [2:0] w_bitCntNxt;
    logic       w_rwNxt;
    logic       w_phaseNxt;
    logic [7:0] w_ptrNxt;
    logic       w_incPendingNxt;
    logic       w_sdaOeNxt;
    logic       w_weNxt;
    logic [7:0] w_diNxt;
    logic [7:0] w_adrWrNxt;
    logic       w_busyNxt;

    // Decoded line events
    logic       w_scl;
    logic       w_sda;
    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_sdaRise;
    logic       w_sdaFall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shiftIn;
    logic       w_lastBit;

    // The sync flops reset to 1 (idle bus) so that leaving reset on an idle
    // bus never looks like a line edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclHist <= 1'b1;
            r_sdaHist <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[0], scl_i};
            r_sdaSync <= {r_sdaSync[0], sda_i};
            r_sclHist <= r_sclSync[1];
            r_sdaHist <= r_sdaSync[1];
        end
    end

    assign w_scl     = r_sclSync[1];
    assign w_sda     = r_sdaSync[1];
    assign w_sclRise = w_scl & ~r_sclHist;
    assign w_sclFall = ~w_scl & r_sclHist;
    assign w_sdaRise = w_sda & ~r_sdaHist;
    assign w_sdaFall = ~w_sda & r_sdaHist;

    // START/STOP need SCL to be high both now and in the history flop, so an
    // SDA change that happens together with an SCL edge is not a line event.
    assign w_start = w_sdaFall & w_scl & r_sclHist;
    assign w_stop  = w_sdaRise & w_scl & r_sclHist;

    assign w_shiftIn = {r_shreg[6:0], w_sda};
    assign w_lastBit = (r_bitCnt == 3'd7);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shreg      <= 8'h00;
            r_bitCnt     <= 3'd0;
            r_rw         <= 1'b0;
            r_phase      <= 1'b0;
            r_ptr        <= 8'h00;
            r_incPending <= 1'b0;
            r_sdaOe      <= 1'b0;
            r_we         <= 1'b0;
            r_di         <= 8'h00;
            r_adrWr      <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_stateNxt;
            r_shreg      <= w_shregNxt;
            r_bitCnt     <= w_bitCntNxt;
            r_rw         <= w_rwNxt;
            r_phase      <= w_phaseNxt;
            r_ptr        <= w_ptrNxt;
            r_incPending <= w_incPendingNxt;
            r_sdaOe      <= w_sdaOeNxt;
            r_we         <= w_weNxt;
            r_di         <= w_diNxt;
            r_adrWr      <= w_adrWrNxt;
            r_busy       <= w_busyNxt;
        end
    end

    // Next-state logic.
    // In the ACK states, r_phase records whether the ACK is already being
    // driven: the first SCL fall pulls SDA low, the second one releases it.
    // In RD_ACK, r_phase records that the master ACKed, so the next SCL fall
    // reloads the shift register.
    always_comb begin
        w_stateNxt      = r_state;
        w_shregNxt      = r_shreg;
        w_bitCntNxt     = r_bitCnt;
        w_rwNxt         = r_rw;
        w_phaseNxt      = r_phase;
        w_ptrNxt        = r_ptr;
        w_incPendingNxt = 1'b0;
        w_sdaOeNxt      = r_sdaOe;
        w_weNxt         = 1'b0;
        w_diNxt         = r_di;
        w_adrWrNxt      = r_adrWr;
        w_busyNxt       = r_busy;

        // The pointer advances in the clock after a write strobe, so the
        // strobe carries the pre-increment address.
        if (r_incPending) begin
            w_ptrNxt = r_ptr + 8'd1;
        end

        if (w_stop) begin
            w_stateNxt  = S_IDLE;
            w_sdaOeNxt  = 1'b0;
            w_busyNxt   = 1'b0;
            w_bitCntNxt = 3'd0;
            w_phaseNxt  = 1'b0;
        end else if (w_start) begin
            // A repeated START inside a live transfer keeps busy asserted.
            // After a NACK or an address mismatch, busy drops here.
            if (r_state == S_IDLE || r_state == S_WAIT_STOP) begin
                w_busyNxt = 1'b0;
            end
            w_stateNxt  = S_DEV_ADDR;
            w_bitCntNxt = 3'd0;
            w_sdaOeNxt  = 1'b0;
            w_phaseNxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end

                S_DEV_ADDR: begin
                    if (w_sclRise) begin
                        w_shregNxt  = w_shiftIn;
                        w_bitCntNxt = r_bitCnt + 3'd1;
                        if (w_lastBit) begin
                            if (w_shiftIn[7:1] == SLAVE_ADDR) begin
                                w_rwNxt    = w_shiftIn[0];
                                w_busyNxt  = 1'b1;
                                w_phaseNxt = 1'b0;
                                w_stateNxt = S_ADDR_ACK;
                            end else begin
                                w_stateNxt = S_IDLE;
                            end
                        end
                    end
                end

                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (w_sclFall) begin
                        if (!r_phase) begin
                            w_sdaOeNxt = 1'b1;
                            w_phaseNxt = 1'b1;
                        end else begin
                            w_phaseNxt  = 1'b0;
                            w_bitCntNxt = 3'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                // The first read bit goes out on this same
                                // fall, so load the byte and drive its MSB now.
                                w_shregNxt = dat_REG;
                                w_sdaOeNxt = ~dat_REG[7];
                                w_stateNxt = S_RD_DATA;
                            end else begin
                                w_sdaOeNxt = 1'b0;
                                w_stateNxt = (r_state == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                            end
                        end
                    end
                end

                S_PTR: begin
                    if (w_sclRise) begin
                        w_shregNxt  = w_shiftIn;
                        w_bitCntNxt = r_bitCnt + 3'd1;
                        if (w_lastBit) begin
                            w_ptrNxt   = w_shiftIn;
                            w_phaseNxt = 1'b0;
                            w_stateNxt = S_PTR_ACK;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (w_sclRise) begin
                        w_shregNxt  = w_shiftIn;
                        w_bitCntNxt = r_bitCnt + 3'd1;
                        if (w_lastBit) begin
                            w_weNxt         = 1'b1;
                            w_adrWrNxt      = r_ptr;
                            w_diNxt         = w_shiftIn;
                            w_incPendingNxt = 1'b1;
                            w_phaseNxt      = 1'b0;
                            w_stateNxt      = S_WR_ACK;
                        end
                    end
                end

                S_RD_DATA: begin
                    if (w_sclFall) begin
                        w_bitCntNxt = r_bitCnt + 3'd1;
                        if (w_lastBit) begin
                            w_sdaOeNxt = 1'b0;
                            w_phaseNxt = 1'b0;
                            w_stateNxt = S_RD_ACK;
                        end else begin
                            w_shregNxt = {r_shreg[6:0], 1'b0};
                            w_sdaOeNxt = ~r_shreg[6];
                        end
                    end
                end

                S_RD_ACK: begin
                    if (w_sclRise && !r_phase) begin
                        if (!w_sda) begin
                            w_ptrNxt   = r_ptr + 8'd1;
                            w_phaseNxt = 1'b1;
                        end else begin
                            w_sdaOeNxt = 1'b0;
                            w_stateNxt = S_WAIT_STOP;
                        end
                    end else if (w_sclFall && r_phase) begin
                        // The pointer moved at the ACK rise, so dat_REG
                        // already shows the next register.
                        w_shregNxt  = dat_REG;
                        w_sdaOeNxt  = ~dat_REG[7];
                        w_bitCntNxt = 3'd0;
                        w_phaseNxt  = 1'b0;
                        w_stateNxt  = S_RD_DATA;
                    end
                end

                S_WAIT_STOP: begin
                    w_sdaOeNxt = 1'b0;
                end

                default: begin
                    w_stateNxt = S_IDLE;
                    w_sdaOeNxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe = r_sdaOe;
    assign we     = r_we;
    assign DI     = r_di;
    assign Adr_wr = r_adrWr;
    assign Adr_rd = r_ptr;
    assign busy   = r_busy;

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
I2C slave protocol engine that sits directly upstream of the 256x8 register block. It decodes START/STOP, device address, register pointer and data bytes from the SCL/SDA lines, issues one-cycle write strobes into the register block, and serialises register contents back to the master on reads. The register pointer auto-increments, so multi-byte bursts work in both directions.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address this slave answers to.

Ports:
clk  input  1  system clock; must run at ≥16x SCL frequency.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  raw SCL line (asynchronous).
sda_i  input  1  raw SDA line (asynchronous).
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
we  output  1  register block write enable; one-clk pulse.
DI  output  8  register block write data.
Adr_wr  output  8  register block write address.
Adr_rd  output  8  register block read address; always equals the pointer.
dat_REG  input  8  register block read data; combinational from Adr_rd.
busy  output  1  high from an address match until STOP, or until the next START after a NACK/mismatch.

Behaviour:
- Input sync: scl_i and sda_i each pass through 2 flops, then a third history flop. Edge detect compares the synced value with the history flop. Decisions are 3 clk behind the pins.
- Line events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on SCL rise.
  - sda_oe changes only on SCL fall, or on STOP/reset.
- Reset (async, rst_n=0): state=IDLE, sda_oe=0, we=0, DI=0, Adr_wr=0, ptr=0 (so Adr_rd=0), busy=0, shift reg=0, bit count=0.
- STOP in any state: go to IDLE, sda_oe=0 on the next clk, busy=0, ptr retained. A partial byte is discarded and never written.
- START in any state, including a repeated START: go to DEV_ADDR, clear bit count, sda_oe=0, ptr retained.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits, MSB first. On the 8th rise, compare bits[7:1] with SLAVE_ADDR.
    - Match: record R/W=bit0, set busy, go to ADDR_ACK.
    - Mismatch: go to IDLE with no ACK.
  - ADDR_ACK:
    - On the SCL fall after the 8th bit, set sda_oe=1.
    - On the next SCL fall, if W: sda_oe=0, go to PTR.
    - On that same fall, if R: load shreg from dat_REG and set sda_oe=~shreg[7], go to RD_DATA.
  - PTR: shift 8 bits, then ptr<=byte, go to PTR_ACK. PTR_ACK drives an ACK exactly as ADDR_ACK does, then goes to WR_DATA.
  - WR_DATA: shift 8 bits.
    - In the clk after the 8th rise: we=1 for exactly one clk, Adr_wr=ptr, DI=byte.
    - In the next clk: ptr<=ptr+1 (mod 256, so 8'hFF wraps to 8'h00).
    - Go to WR_ACK, which ACKs, then returns to WR_DATA.
  - RD_DATA:
    - On each SCL fall, shift and set sda_oe=~shreg[7] for the next bit.
    - After the 8th bit's fall, sda_oe=0 and go to RD_ACK.
  - RD_ACK: sample the master's bit on SCL rise.
    - 0 (ACK): ptr<=ptr+1 (wrap), then on the next SCL fall load shreg from dat_REG at the new Adr_rd and go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0, ignore bits until STOP or START.
- we is never asserted outside WR_DATA completion. Only 8 complete data bits produce a write.
- Adr_rd=ptr at all times. dat_REG is captured only at the shreg load instant.

Test Plan:
- Reset check: rst_n=0 mid-read while sda_oe=1 -> sda_oe=0 within the same clk (async), state IDLE, ptr=0. Then after rst_n=1, a fresh write to 0xA0/0x00/0x11 -> ACKed normally, we with Adr_wr=0x00 DI=0x11.
- Burst write: START, 0xA0, 0x10, 0xA5, 0x3C, STOP -> four ACKs (sda_oe=1 for each ACK bit). Two we pulses, each 1 clk: (Adr_wr=0x10, DI=0xA5) then (0x11, 0x3C). Ptr=0x12 after STOP.
- Random read via repeated START: START, 0xA0, 0x10, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP -> SDA reproduces 0xA5 then 0x3C MSB-first. No we pulses. Ptr=0x11 after the NACK.
- Address mismatch: START, 0xA2, 0x10, 0x55, STOP -> sda_oe stays 0 throughout, no we, busy stays 0, ptr unchanged.
- Pointer wrap: write 0xA0, 0xFF, 0x01, 0x02 -> we at Adr_wr=0xFF DI=0x01, then Adr_wr=0x00 DI=0x02.
- Aborted byte: START, 0xA0, 0x20, 4 data bits then STOP -> no we pulse, sda_oe=0, state IDLE, ptr=0x20.
